// File: rtl/tm1637_frame_tx.sv
// TM1637 display frame transmitter: sends data-command, address+4 segment bytes, display-control.
// Optional macro TM1637_COLON_EN adds a colon input that drives bit7 of the second digit.
module tm1637_frame_tx #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] data,
  input  logic [2:0]  brightness,
  output logic        scl,
  output logic        sda,
  output logic        busy,
  output logic        done
`ifdef TM1637_COLON_EN
  ,
  input  logic        colon
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_BIT_LO,
    S_BIT_HI,
    S_ACK_LO,
    S_ACK_HI,
    S_STOP_A,
    S_STOP_B,
    S_STOP_C
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [2:0]       byte_q;
  logic [1:0]       tx_q;
  logic [15:0]      data_q;
  logic [2:0]       bri_q;
  logic             scl_q;
  logic             sda_q;
  logic             busy_q;
  logic             done_q;
  logic             colon_bit;

`ifdef TM1637_COLON_EN
  logic colon_q;
  assign colon_bit = colon_q;
`else
  assign colon_bit = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Byte idx of transaction tx: 0 = data command, 1 = address + digits, 2 = display control.
  function automatic logic [7:0] byte_at(input logic [1:0] tx, input logic [2:0] idx,
                                         input logic [15:0] d, input logic [2:0] b,
                                         input logic c);
    logic [7:0] v;
    case (tx)
      2'd1: begin
        case (idx)
          3'd0:    v = 8'hC0;
          3'd1:    v = {1'b0, seg7(d[15:12])};
          3'd2:    v = {c,    seg7(d[11:8])};
          3'd3:    v = {1'b0, seg7(d[7:4])};
          default: v = {1'b0, seg7(d[3:0])};
        endcase
      end
      2'd2:    v = {5'b10001, b};
      default: v = 8'h40;
    endcase
    return v;
  endfunction

  logic       div_wrap;
  logic [2:0] bit_nxt;
  logic [2:0] byte_nxt;
  logic [2:0] last_byte;
  logic [7:0] cur_byte;
  logic [7:0] next_byte;

  assign div_wrap  = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_nxt   = bit_q + 3'd1;
  assign byte_nxt  = byte_q + 3'd1;
  assign last_byte = (tx_q == 2'd1) ? 3'd4 : 3'd0;
  assign cur_byte  = byte_at(tx_q, byte_q, data_q, bri_q, colon_bit);
  assign next_byte = byte_at(tx_q, byte_nxt, data_q, bri_q, colon_bit);

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= '0;
      data_q  <= '0;
      bri_q   <= '0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TM1637_COLON_EN
      colon_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        div_q <= '0;
        scl_q <= 1'b1;
        sda_q <= 1'b1;
        if (start) begin
          data_q  <= data;
          bri_q   <= brightness;
`ifdef TM1637_COLON_EN
          colon_q <= colon;
`endif
          tx_q    <= 2'd0;
          byte_q  <= 3'd0;
          bit_q   <= 3'd0;
          state_q <= S_START;
          sda_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
      end else if (!div_wrap) begin
        div_q <= div_q + DIV_W'(1);
      end else begin
        div_q <= '0;
        case (state_q)
          S_START: begin
            state_q <= S_BIT_LO;
            bit_q   <= 3'd0;
            scl_q   <= 1'b0;
            sda_q   <= cur_byte[0];
          end
          S_BIT_LO: begin
            state_q <= S_BIT_HI;
            scl_q   <= 1'b1;
          end
          S_BIT_HI: begin
            scl_q <= 1'b0;
            if (bit_q == 3'd7) begin
              state_q <= S_ACK_LO;
              sda_q   <= 1'b1;
            end else begin
              state_q <= S_BIT_LO;
              bit_q   <= bit_nxt;
              sda_q   <= cur_byte[bit_nxt];
            end
          end
          S_ACK_LO: begin
            state_q <= S_ACK_HI;
            scl_q   <= 1'b1;
          end
          S_ACK_HI: begin
            scl_q <= 1'b0;
            bit_q <= 3'd0;
            if (byte_q != last_byte) begin
              state_q <= S_BIT_LO;
              byte_q  <= byte_nxt;
              sda_q   <= next_byte[0];
            end else begin
              state_q <= S_STOP_A;
              byte_q  <= 3'd0;
              sda_q   <= 1'b0;
            end
          end
          S_STOP_A: begin
            state_q <= S_STOP_B;
            scl_q   <= 1'b1;
          end
          S_STOP_B: begin
            state_q <= S_STOP_C;
            sda_q   <= 1'b1;
          end
          S_STOP_C: begin
            if (tx_q == 2'd2) begin
              state_q <= S_IDLE;
              tx_q    <= 2'd0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_START;
              tx_q    <= tx_q + 2'd1;
              sda_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign scl  = scl_q;
  assign sda  = sda_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_tm1637_frame_tx.sv
// Bench for tm1637_frame_tx: a line monitor decodes START/STOP/bytes and a byte-list model predicts frames.
module tb_tm1637_frame_tx;

  localparam int CLK_DIV = 2;
  localparam int SEQ_CYC = 138 * CLK_DIV;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] data;
  logic [2:0]  brightness;
  logic        scl;
  logic        sda;
  logic        busy;
  logic        done;
  logic        colon_v;
`ifdef TM1637_COLON_EN
  logic        colon;
`endif

  tm1637_frame_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk25      (clk),
    .rst        (rst),
    .start      (start),
    .data       (data),
    .brightness (brightness),
    .scl        (scl),
    .sda        (sda),
    .busy       (busy),
    .done       (done)
`ifdef TM1637_COLON_EN
    ,
    .colon      (colon)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] seg_tab [16];

  int busy_cnt, done_cnt, done_bad, starts, stops, viol, ack_bad, bitcnt;
  logic [7:0] shreg;
  logic scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0;

  initial begin
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  end

  // Line monitor: decodes the two-wire protocol from sampled scl/sda
  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      if (busy || !busy_p) done_bad++;
    end
    if (sda !== sda_p) begin
      if (scl && scl_p) begin
        if (!sda) begin
          starts++;
          if (bitcnt != 0) viol++;
        end else begin
          stops++;
          if (bitcnt != 1) viol++;
        end
        bitcnt = 0;
      end else if (scl && !scl_p) begin
        viol++;
      end
    end
    if (scl && !scl_p) begin
      if (bitcnt < 8) begin
        shreg[bitcnt] = sda;
        bitcnt++;
      end else begin
        if (sda !== 1'b1) ack_bad++;
        got_q.push_back(shreg);
        bitcnt = 0;
      end
    end
    scl_p  = scl;
    sda_p  = sda;
    busy_p = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the frame is a fixed byte list built from the latched inputs
  task automatic build_exp(input logic [15:0] d, input logic [2:0] b, input logic c);
    logic [7:0] s1;
    s1 = seg_tab[d[11:8]];
`ifdef TM1637_COLON_EN
    s1[7] = c;
`else
    s1[7] = 1'b0 & c;
`endif
    exp_q.delete();
    exp_q.push_back(8'h40);
    exp_q.push_back(8'hC0);
    exp_q.push_back(seg_tab[d[15:12]]);
    exp_q.push_back(s1);
    exp_q.push_back(seg_tab[d[7:4]]);
    exp_q.push_back(seg_tab[d[3:0]]);
    exp_q.push_back(8'h88 | {5'd0, b});
  endtask

  // Driver: called at negedge+1; start is sampled at the following posedge
  task automatic start_seq(input logic [15:0] d, input logic [2:0] b, input logic c);
    busy_cnt = 0; done_cnt = 0; done_bad = 0; starts = 0; stops = 0;
    viol = 0; ack_bad = 0; bitcnt = 0;
    got_q.delete();
    build_exp(d, b, c);
    data = d;
    brightness = b;
    colon_v = c;
`ifdef TM1637_COLON_EN
    colon = c;
`endif
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < SEQ_CYC + 50; i++) begin
      if (done_cnt > 0) break;
      @(negedge clk); #1;
    end
    chk("done_seen", (done_cnt > 0), 1);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_busy_cycles"}, busy_cnt, SEQ_CYC);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_done_timing"}, done_bad, 0);
    chk({tag, "_starts"}, starts, 3);
    chk({tag, "_stops"}, stops, 3);
    chk({tag, "_proto_viol"}, viol, 0);
    chk({tag, "_ack_released"}, ack_bad, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data = '0; brightness = '0; colon_v = 1'b0;
`ifdef TM1637_COLON_EN
    colon = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;

    // Basic frame; colon forced on when the option is built in
    start_seq(16'h1234, 3'd7, 1'b1);
    chk("start_busy", busy, 1);
    chk("start_scl", scl, 1);
    chk("start_sda", sda, 0);
    wait_done();
    check_seq("f1234");

    // Blank digits, launched in the done cycle
    start_seq(16'hA9F0, 3'd3, 1'b0);
    wait_done();
    check_seq("fA9F0");

    // Start while busy is ignored, new data not picked up
    start_seq(16'h5678, 3'd0, 1'b1);
    repeat (10) begin @(negedge clk); #1; end
    data = 16'h0000;
    brightness = 3'd5;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    wait_done();
    check_seq("ignore");
    repeat (5) begin @(negedge clk); #1; end
    chk("ignore_not_queued", busy, 0);

    // Reset in mid-sequence aborts without a done pulse
    start_seq(16'h9876, 3'd2, 1'b0);
    repeat (100) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_scl", scl, 1);
    chk("abort_sda", sda, 1);
    chk("abort_busy", busy, 0);
    rst = 1'b0;
    repeat (20) begin @(negedge clk); #1; end
    chk("abort_no_done", done_cnt, 0);
    start_seq(16'h0123, 3'd5, 1'b0);
    wait_done();
    check_seq("after_abort");

    // Random frames
    for (int k = 0; k < 4; k++) begin
      start_seq(16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      wait_done();
      check_seq($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tm1637_frame_tx.md
TM1637_FRAME_TX -- requirements
Module: tm1637_frame_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning clk25 cycles per SCL half-period (H); 25 MHz / (2*125) = 100 kHz SCL.
REQ-002 SHALL have port clk25  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to send one display update.
REQ-005 SHALL have port data  input  16  four BCD digits: data[15:12]=digit0 (first sent), data[11:8]=digit1, data[7:4]=digit2, data[3:0]=digit3.
REQ-006 SHALL have port brightness  input  3  TM1637 pulse-width level, 0..7.
REQ-007 SHALL have port scl  output  1  TM1637 clock line.
REQ-008 SHALL have port sda  output  1  TM1637 data line; a driven 1 releases the line.
REQ-009 SHALL have port busy  output  1  high while a frame sequence is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the sequence completes.

Function
REQ-011 SHALL sample start only when busy=0; start while busy=1 SHALL be ignored and not queued.
REQ-012 SHALL latch data and brightness on the accepted start edge; later input changes SHALL NOT affect the current sequence.
REQ-013 SHALL assert busy in the cycle after start is accepted and hold it for exactly 138*CLK_DIV cycles.
REQ-014 SHALL send three transactions in order: [0x40], [0xC0, seg0, seg1, seg2, seg3], [0x88|brightness].
REQ-015 SHALL transmit each byte LSB first, then one ACK slot, giving 9 bit periods per byte.
REQ-016 SHALL make each bit period 2H: SCL low for H with SDA updated on the first cycle of the low half, then SCL high for H.
REQ-017 SHALL drive sda=1 during every ACK slot and SHALL NOT check the acknowledge.
REQ-018 SHALL form START as: SCL=1, SDA 1->0, hold for H, then enter the first bit-low phase.
REQ-019 SHALL form STOP as: SCL=0 with SDA=0 for H, then SCL=1 with SDA=0 for H, then SCL=1 with SDA=1 for H.
REQ-020 SHALL step through FSM states IDLE -> START -> BIT_LO <-> BIT_HI -> ACK_LO -> ACK_HI -> (next byte: BIT_LO | else STOP_A -> STOP_B -> STOP_C) -> next transaction START | IDLE.
REQ-021 SHALL map digits to segments (bit0=a .. bit6=g) as: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-022 SHALL encode digit values 10..15 as 0x00 (blank) with no error indication.
REQ-023 SHALL hold the divider counter at 0 in IDLE and wrap it at CLK_DIV-1, with each wrap advancing the FSM.
REQ-024 SHALL pulse done=1 for one cycle, in the first cycle busy=0, and a start in that same cycle SHALL be accepted.
REQ-025 SHALL hold scl=1 and sda=1 in IDLE.

Reset
REQ-026 SHALL force, on rst=1 at a clock edge: scl=1, sda=1, busy=0, done=0, FSM=IDLE, and all counters and latches to 0.
REQ-027 SHALL abort a sequence in progress when rst is asserted, without generating a STOP, and SHALL NOT assert done for it.
REQ-028 SHALL give rst priority over a simultaneous start.

Configuration
REQ-029 SHALL honour macro TM1637_COLON_EN; when defined, it adds input port colon (1 bit), latched with data, which drives bit7 of seg1.
REQ-030 SHALL, without TM1637_COLON_EN, omit the colon port and force bit7 of every segment byte to 0.

Verification
REQ-031 SHALL verify: CLK_DIV=2, data=0x1234, brightness=7, start pulse -> decoded bytes 0x40 / 0xC0,0x06,0x5B,0x4F,0x66 / 0x8F; busy high for 276 cycles; one done pulse.
REQ-032 SHALL verify: data=0xA9F0 -> segment bytes 0x00,0x6F,0x00,0x3F.
REQ-033 SHALL verify: start reasserted 10 cycles into a sequence, with data changed to 0x0000 -> ignored; original bytes sent; exactly one done.
REQ-034 SHALL verify: rst asserted 100 cycles into a sequence -> next cycle scl=1, sda=1, busy=0; no done; a new start runs a full correct sequence.
REQ-035 SHALL verify: protocol monitor -> SDA changes only while SCL=0, except at START (1->0) and STOP (0->1) edges with SCL=1; 3 STARTs and 3 STOPs per sequence.
REQ-036 SHALL verify: TM1637_COLON_EN defined, colon=1, data=0x1234 -> seg1=0xDB; other bytes unchanged.
